pll_lock_sequencer: RTL and testbench

//  Sequences the system rPLL: holds PLL RESET after power-up, waits for LOCK with timeout/retry,

---
 rtl/pll_seq_pkg.sv | 40 ++++
 rtl/pll_lock_sequencer_sync_2ff.sv | 31 +++
 rtl/pll_lock_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and constants for the PLL lock sequencer.
//   state_e    : sequencer states (RST_HOLD, WAIT_LOCK, SETTLE, RUN, FAULT)
//   RELOCK_W   : width of the saturating relock event counter
//   DEF_*      : default timing constants for a 27 MHz board clock
//   max3       : elaboration helper used to size the shared cycle counter
//   sat_inc    : saturating increment for the relock counter
// -----------------------------------------------------------------------------
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAULT
  } state_e;

  localparam int unsigned RELOCK_W = 8;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 27000;  // 1 ms
  localparam int unsigned DEF_SETTLE_CYCLES = 2700;   // 100 us
  localparam int unsigned DEF_LOSS_FILTER   = 4;
  localparam int unsigned DEF_MAX_RETRIES   = 7;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Output has two cycles of latency; both flops clear to 0 on reset.
//   clk   in  1  destination clock
//   rst_n in  1  async active-low reset
//   d     in  1  asynchronous input level
//   q     out 1  synchronized level
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: flops use non-blocking assignments so meta and q both sample their
  // pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
// Sequences an rPLL from the 27 MHz board clock: pulses PLL RESET, waits for
// LOCK with timeout/retry, qualifies LOCK over a settle window, then releases
// the downstream reset. Lock loss (filtered) or a relock request re-runs the
// whole sequence.
//
// Optional feature macro: PLL_FAULT_LATCH_EN
//   defined   : MAX_RETRIES consecutive timeouts park the FSM in FAULT with a
//               sticky fault flag; only sys_rst_n leaves FAULT.
//   undefined : retries are unbounded, fault is tied low.
//
// Ports
//   sys_clk    in  1  board clock (never a PLL output clock)
//   sys_rst_n  in  1  async active-low reset
//   pll_lock   in  1  rPLL LOCK, asynchronous to sys_clk
//   relock_req in  1  single-cycle request for a full re-sequence
//   pll_reset  out 1  rPLL RESET, active high
//   pll_ready  out 1  lock qualified, sequencer in RUN
//   dom_rst_n  out 1  active-low reset for PLL-clocked logic
//   relock_cnt out 8  lock-loss/relock events, saturating at 255
//   fault      out 1  sticky retry-exhaustion flag
// -----------------------------------------------------------------------------
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned LOSS_FILTER   = DEF_LOSS_FILTER,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                pll_lock,
  input  logic                relock_req,
  output logic                pll_reset,
  output logic                pll_ready,
  output logic                dom_rst_n,
  output logic [RELOCK_W-1:0] relock_cnt,
  output logic                fault
);

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || SETTLE_CYCLES < 1 ||
      LOSS_FILTER < 1 || MAX_RETRIES < 1) begin : g_param_check
    $error("pll_lock_sequencer: all timing parameters must be >= 1");
  end

  // One counter is shared by RST_HOLD, WAIT_LOCK and SETTLE, so it is sized
  // for the longest of the three windows.
  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned LOSS_W  = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

  localparam logic [CNT_W-1:0]  RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST    = LOSS_W'(LOSS_FILTER - 1);

  logic              lock_s;
  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [LOSS_W-1:0] loss_cnt;

`ifdef PLL_FAULT_LATCH_EN
  localparam int unsigned        RETRY_W    = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
  logic [RETRY_W-1:0] retry;
`else
  assign fault = 1'b0;
`endif

  sync_2ff u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Outputs are updated on the same edge as the state they belong to, so
  // pll_ready/dom_rst_n rise on the edge entering RUN and fall on the edge
  // leaving it, and pll_reset tracks RST_HOLD/FAULT exactly.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= RST_HOLD;
      cnt        <= '0;
      loss_cnt   <= '0;
      pll_reset  <= 1'b1;
      pll_ready  <= 1'b0;
      dom_rst_n  <= 1'b0;
      relock_cnt <= '0;
`ifdef PLL_FAULT_LATCH_EN
      retry      <= '0;
      fault      <= 1'b0;
`endif
    end else if (relock_req && state != FAULT) begin
      // Forced re-sequence overrides everything; when it coincides with a
      // filtered lock loss in RUN this is still a single relock event.
      state     <= RST_HOLD;
      cnt       <= '0;
      loss_cnt  <= '0;
      pll_reset <= 1'b1;
      pll_ready <= 1'b0;
      dom_rst_n <= 1'b0;
`ifdef PLL_FAULT_LATCH_EN
      retry     <= '0;
`endif
      if (state == RUN) relock_cnt <= sat_inc(relock_cnt);
    end else begin
      case (state)
        RST_HOLD: begin
          if (cnt == RST_LAST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          // Lock seen on the timeout cycle still counts as lock.
          if (lock_s) begin
            state <= SETTLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt       <= '0;
            pll_reset <= 1'b1;
`ifdef PLL_FAULT_LATCH_EN
            if (retry == RETRY_LAST) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state <= RST_HOLD;
              retry <= retry + 1'b1;
            end
`else
            state <= RST_HOLD;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SETTLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == SETTLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            loss_cnt  <= '0;
            pll_ready <= 1'b1;
            dom_rst_n <= 1'b1;
`ifdef PLL_FAULT_LATCH_EN
            retry     <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN: begin
          // Only LOSS_FILTER consecutive low samples count as lock loss.
          if (lock_s) begin
            loss_cnt <= '0;
          end else if (loss_cnt == LOSS_LAST) begin
            state      <= RST_HOLD;
            cnt        <= '0;
            loss_cnt   <= '0;
            pll_reset  <= 1'b1;
            pll_ready  <= 1'b0;
            dom_rst_n  <= 1'b0;
            relock_cnt <= sat_inc(relock_cnt);
          end else begin
            loss_cnt <= loss_cnt + 1'b1;
          end
        end

`ifdef PLL_FAULT_LATCH_EN
        FAULT: begin
          pll_reset <= 1'b1;
          pll_ready <= 1'b0;
          dom_rst_n <= 1'b0;
        end
`endif

        default: begin
          state     <= RST_HOLD;
          cnt       <= '0;
          loss_cnt  <= '0;
          pll_reset <= 1'b1;
          pll_ready <= 1'b0;
          dom_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
// Self-checking bench for pll_lock_sequencer with small timing parameters.
// A behavioural model (countdown timers and high/low streaks over a two-sample
// lock delay line) predicts every output after every clock edge; directed
// steps add arithmetic checks on sequence timing, loss filtering, relock
// counting/saturation and asynchronous reset, then a randomized lock/relock
// phase runs against the model. PLL_FAULT_LATCH_EN enables the fault steps.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int RST    = 4;
  localparam int TO     = 20;
  localparam int SET    = 8;
  localparam int LOSS   = 3;
  localparam int MAXR   = 3;
`ifdef PLL_FAULT_LATCH_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       pll_ready;
  logic       dom_rst_n;
  logic [7:0] relock_cnt;
  logic       fault;

  int n_tests;
  int n_fail;

  pll_lock_sequencer #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TO),
    .SETTLE_CYCLES (SET),
    .LOSS_FILTER   (LOSS),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pll_lock   (pll_lock),
    .relock_req (relock_req),
    .pll_reset  (pll_reset),
    .pll_ready  (pll_ready),
    .dom_rst_n  (dom_rst_n),
    .relock_cnt (relock_cnt),
    .fault      (fault)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural reference model ----------------
  typedef enum {P_HOLD, P_WAIT, P_SETTLE, P_RUN, P_FAULT} phase_t;
  phase_t ph;
  int     left;       // cycles remaining in the hold / wait window
  int     streak;     // consecutive highs (settle) or lows (run)
  int     relocks;
  int     timeouts;
  bit     s1, s2;     // lock as seen one and two edges ago
  bit     m_fault;

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    ph = P_HOLD; left = RST; streak = 0; relocks = 0; timeouts = 0;
    s1 = 1'b0; s2 = 1'b0; m_fault = 1'b0;
  endtask

  task automatic enter_hold();
    ph = P_HOLD; left = RST; streak = 0;
  endtask

  task automatic model_edge(input bit lk, input bit req);
    bit ls;
    ls = s2; s2 = s1; s1 = lk;
    if (req && ph != P_FAULT) begin
      if (ph == P_RUN) relocks = sat255(relocks + 1);
      timeouts = 0;
      enter_hold();
    end else begin
      case (ph)
        P_HOLD: begin
          left--;
          if (left == 0) begin ph = P_WAIT; left = TO; end
        end
        P_WAIT: begin
          if (ls) begin
            ph = P_SETTLE; streak = 0;
          end else begin
            left--;
            if (left == 0) begin
              timeouts++;
              if (FAULT_EN && timeouts == MAXR) begin
                ph = P_FAULT; m_fault = 1'b1;
              end else begin
                enter_hold();
              end
            end
          end
        end
        P_SETTLE: begin
          if (!ls) begin
            ph = P_WAIT; left = TO;
          end else begin
            streak++;
            if (streak == SET) begin ph = P_RUN; streak = 0; timeouts = 0; end
          end
        end
        P_RUN: begin
          if (ls) begin
            streak = 0;
          end else begin
            streak++;
            if (streak == LOSS) begin
              relocks = sat255(relocks + 1);
              enter_hold();
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string where);
    bit exp_reset, exp_ready;
    exp_reset = (ph == P_HOLD) || (ph == P_FAULT);
    exp_ready = (ph == P_RUN);
    check({where, ".pll_reset"},  32'(pll_reset),  32'(exp_reset));
    check({where, ".pll_ready"},  32'(pll_ready),  32'(exp_ready));
    check({where, ".dom_rst_n"},  32'(dom_rst_n),  32'(exp_ready));
    check({where, ".relock_cnt"}, 32'(relock_cnt), 32'(relocks));
    check({where, ".fault"},      32'(fault),      32'(m_fault));
  endtask

  task automatic step();
    bit lk, rq;
    lk = pll_lock;
    rq = relock_req;
    @(posedge sys_clk);
    #1;
    model_edge(lk, rq);
    compare_all("model");
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic run_until_ready(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pll_ready && n < bound);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, m, k;
    int base, glitch;

    n_tests    = 0;
    n_fail     = 0;
    sys_rst_n  = 1'b0;
    pll_lock   = 1'b0;
    relock_req = 1'b0;
    model_reset();

    // Power-up: reset values, reset pulse length, lock-to-ready latency.
    do_reset();
    n = 0;
    while (pll_reset && n < 50) begin step(); n++; end
    check("powerup_reset_cycles", 32'(n), 32'(RST));
    steps(2);
    pll_lock = 1'b1;
    run_until_ready(50, n);
    check("powerup_lock_to_ready", 32'(n), 32'(2 + SET + 1));
    check("powerup_dom_rst_n", 32'(dom_rst_n), 32'd1);
    check("powerup_relock_cnt", 32'(relock_cnt), 32'd0);

    // Loss filter: a 2-cycle drop is ignored, a 3-cycle drop re-sequences.
    pll_lock = 1'b0; steps(2);
    pll_lock = 1'b1; steps(4);
    check("short_glitch_ready", 32'(pll_ready), 32'd1);
    pll_lock = 1'b0; steps(2);
    pll_lock = 1'b1; steps(3);
    check("short_glitch_ready_late", 32'(pll_ready), 32'd1);
    pll_lock = 1'b0; steps(LOSS + 2);
    check("loss_ready", 32'(pll_ready), 32'd0);
    check("loss_dom_rst_n", 32'(dom_rst_n), 32'd0);
    check("loss_pll_reset", 32'(pll_reset), 32'd1);
    check("loss_relock_cnt", 32'(relock_cnt), 32'd1);
    pll_lock = 1'b1;
    run_until_ready(100, n);
    check("loss_recovered", 32'(pll_ready), 32'd1);

    // Settle glitch: one low sample mid-SETTLE restarts the full window.
    pll_lock = 1'b0;
    n = 0;
    while (!(ph == P_WAIT) && n < 100) begin step(); n++; end
    check("glitch_reach_wait", 32'(pll_reset), 32'd0);
    pll_lock = 1'b1; steps(5);
    pll_lock = 1'b0; step();
    pll_lock = 1'b1;
    run_until_ready(50, n);
    check("glitch_rise_to_ready", 32'(n), 32'(2 + SET + 1));
    check("glitch_relock_cnt", 32'(relock_cnt), 32'd2);

    // Relock request on the same edge as the third low sample: one event.
    pll_lock = 1'b0; steps(LOSS + 1);
    relock_req = 1'b1; step();
    relock_req = 1'b0;
    check("coincident_relock_cnt", 32'(relock_cnt), 32'd3);
    check("coincident_pll_reset", 32'(pll_reset), 32'd1);
    pll_lock = 1'b1;
    run_until_ready(100, n);
    check("coincident_recovered", 32'(pll_ready), 32'd1);

    // Timeout: with lock held low pll_reset re-pulses every RST+TO cycles.
    do_reset();
    pll_lock = 1'b0;
    n = 0; while (pll_reset && n < 50) begin step(); n++; end
    m = 0; while (!pll_reset && m < 50) begin step(); m++; end
    k = 0; while (pll_reset && k < 50) begin step(); k++; end
    check("timeout_wait_cycles", 32'(m), 32'(TO));
    check("timeout_period", 32'(m + k), 32'(RST + TO));
    check("timeout_no_ready", 32'(pll_ready), 32'd0);

`ifdef PLL_FAULT_LATCH_EN
    // Fault latch: MAXR timeouts park the sequencer; only reset clears it.
    do_reset();
    pll_lock = 1'b0;
    n = 0; while (!fault && n < 500) begin step(); n++; end
    check("fault_after_timeouts", 32'(n), 32'(MAXR * (RST + TO)));
    pll_lock = 1'b1; steps(40);
    check("fault_sticky", 32'(fault), 32'd1);
    check("fault_pll_reset", 32'(pll_reset), 32'd1);
    check("fault_ready", 32'(pll_ready), 32'd0);
    relock_req = 1'b1; step(); relock_req = 1'b0; steps(20);
    check("fault_ignores_relock", 32'(fault), 32'd1);
    do_reset();
    check("fault_cleared", 32'(fault), 32'd0);
`endif

    // 300 forced relocks from RUN saturate the event counter at 255.
    do_reset();
    pll_lock = 1'b1;
    run_until_ready(100, n);
    for (int i = 0; i < 300; i++) begin
      relock_req = 1'b1; step(); relock_req = 1'b0;
      run_until_ready(100, n);
    end
    check("relock_saturated", 32'(relock_cnt), 32'd255);
    check("relock_saturated_ready", 32'(pll_ready), 32'd1);

    // Asynchronous reset mid-SETTLE takes effect without a clock edge.
    relock_req = 1'b1; step(); relock_req = 1'b0;
    n = 0; while (ph != P_SETTLE && n < 50) begin step(); n++; end
    steps(2);
    check("async_pre_pll_reset", 32'(pll_reset), 32'd0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_pll_reset", 32'(pll_reset), 32'd1);
    check("async_ready", 32'(pll_ready), 32'd0);
    check("async_dom_rst_n", 32'(dom_rst_n), 32'd0);
    check("async_relock_cnt", 32'(relock_cnt), 32'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Randomized lock behaviour: stable stretches, short glitches, flips,
    // occasional relock requests, all checked against the model.
    base = 1; glitch = 0;
    for (int i = 0; i < 2000; i++) begin
      if (glitch > 0) begin
        pll_lock = ~base[0];
        glitch--;
      end else begin
        pll_lock = base[0];
        if ($urandom_range(0, 39) == 0) glitch = $urandom_range(1, 4);
        if ($urandom_range(0, 149) == 0) base = 1 - base;
      end
      relock_req = ($urandom_range(0, 99) == 0);
      step();
    end
    relock_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
